// File: rtl/seq_det_pkg.sv
// rtl/seq_det_pkg.sv - shared types and default widths for the sequence-detector scheduler
//
// Purpose : scheduler/detector state enums and default parameter values.
// Ports   : none (package).
package seq_det_pkg;

  localparam int DEF_N_REQ  = 4;
  localparam int DEF_DATA_W = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    RESP  = 2'd2
  } sched_state_t;

  typedef enum logic {
    S0 = 1'b0,
    S1 = 1'b1
  } det_state_t;

endpackage

// File: rtl/seq_det_core.sv
// rtl/seq_det_core.sv - bit-serial Mealy "0->1" transition detector
//
// Purpose : flags a hit on every 1 that follows at least one 0 since the
//           last hit. hit is combinational in the cycle the bit is presented.
// Ports   : clk    - clock, rising edge
//           rstn   - asynchronous active-low reset (state -> S0)
//           clr    - synchronous clear to S0 (start of a new word)
//           bit_en - bit_in is valid this cycle
//           bit_in - serial data bit
//           hit    - 0->1 transition seen on this bit
module seq_det_core
  import seq_det_pkg::*;
(
  input  logic clk,
  input  logic rstn,
  input  logic clr,
  input  logic bit_en,
  input  logic bit_in,
  output logic hit
);

  det_state_t state, state_nxt;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= S0;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    hit       = 1'b0;
    if (clr) begin
      state_nxt = S0;
    end else if (bit_en) begin
      case (state)
        S0: begin
          if (!bit_in) state_nxt = S1;
        end
        S1: begin
          if (bit_in) begin
            state_nxt = S0;
            hit       = 1'b1;
          end
        end
        default: state_nxt = S0;
      endcase
    end
  end

endmodule

// File: rtl/seq_det_sched.sv
// rtl/seq_det_sched.sv - round-robin scheduler sharing one seq_det_core among N_REQ requesters
//
// Purpose : grants one requester at a time, shifts its word MSB-first through
//           the detector, counts hits and returns {id, count} on a
//           valid/ready response port.
// Ports   : clk, rstn           - clock / asynchronous active-low reset
//           req_valid[N_REQ]    - per-requester word valid
//           req_data            - packed words, requester i at [i*DATA_W +: DATA_W]
//           req_ready[N_REQ]    - one-hot grant (combinational, IDLE only)
//           rsp_valid/rsp_ready - result handshake
//           rsp_id, rsp_cnt     - requester index and hit count of the result
//           busy                - high in SHIFT and RESP
// Option  : SEQ_DET_IRQ_EN adds irq_thr, irq_clr and a sticky irq output.
module seq_det_sched
  import seq_det_pkg::*;
#(
  parameter int N_REQ  = DEF_N_REQ,
  parameter int DATA_W = DEF_DATA_W,
  parameter int ID_W   = $clog2(N_REQ),
  parameter int CNT_W  = $clog2(DATA_W) + 1
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic [N_REQ-1:0]        req_valid,
  input  logic [N_REQ*DATA_W-1:0] req_data,
  output logic [N_REQ-1:0]        req_ready,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [ID_W-1:0]         rsp_id,
  output logic [CNT_W-1:0]        rsp_cnt,
  output logic                    busy
`ifdef SEQ_DET_IRQ_EN
  ,
  input  logic [CNT_W-1:0]        irq_thr,
  input  logic                    irq_clr,
  output logic                    irq
`endif
);

  localparam int IDX_W = $clog2(DATA_W);

  sched_state_t      state, state_nxt;
  logic [ID_W-1:0]   rr_ptr, rr_nxt;
  logic [ID_W-1:0]   grant_id, id_hi, id_any, cur_id;
  logic              any_valid, found_hi;
  logic [DATA_W-1:0] shreg;
  logic [IDX_W-1:0]  bit_idx;
  logic [CNT_W-1:0]  cnt, cnt_inc;
  logic              last_bit;
  logic              det_clr, det_en, det_hit;

  // Round-robin pick: lowest valid index at/after rr_ptr, otherwise the
  // lowest valid index overall (the wrap). Descending loop so the lowest
  // matching index is the one left standing.
  always_comb begin
    any_valid = 1'b0;
    found_hi  = 1'b0;
    id_hi     = '0;
    id_any    = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (req_valid[i]) begin
        any_valid = 1'b1;
        id_any    = ID_W'(i);
        if (ID_W'(i) >= rr_ptr) begin
          found_hi = 1'b1;
          id_hi    = ID_W'(i);
        end
      end
    end
    grant_id = found_hi ? id_hi : id_any;
  end

  assign rr_nxt   = (grant_id == ID_W'(N_REQ - 1)) ? '0 : grant_id + 1'b1;
  assign last_bit = (bit_idx == IDX_W'(DATA_W - 1));
  assign cnt_inc  = cnt + CNT_W'(det_hit);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // req_ready is gated by rstn so every output reads 0 while reset is held,
  // even though the IDLE grant is otherwise purely combinational.
  always_comb begin
    state_nxt = state;
    req_ready = '0;
    rsp_valid = 1'b0;
    busy      = 1'b0;
    det_clr   = 1'b0;
    det_en    = 1'b0;
    case (state)
      IDLE: begin
        if (any_valid) begin
          req_ready[grant_id] = rstn;
          det_clr             = 1'b1;
          state_nxt           = SHIFT;
        end
      end
      SHIFT: begin
        busy   = 1'b1;
        det_en = 1'b1;
        if (last_bit) state_nxt = RESP;
      end
      RESP: begin
        busy      = 1'b1;
        rsp_valid = 1'b1;
        if (rsp_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rr_ptr  <= '0;
      cur_id  <= '0;
      shreg   <= '0;
      bit_idx <= '0;
      cnt     <= '0;
      rsp_id  <= '0;
      rsp_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (any_valid) begin
            shreg   <= req_data[grant_id*DATA_W +: DATA_W];
            cur_id  <= grant_id;
            bit_idx <= '0;
            cnt     <= '0;
            rr_ptr  <= rr_nxt;
          end
        end
        SHIFT: begin
          // MSB is always the current bit; shift left to expose the next one.
          shreg   <= {shreg[DATA_W-2:0], 1'b0};
          bit_idx <= bit_idx + 1'b1;
          cnt     <= cnt_inc;
          if (last_bit) begin
            rsp_id  <= cur_id;
            rsp_cnt <= cnt_inc;
          end
        end
        default: ;
      endcase
    end
  end

  seq_det_core u_core (
    .clk    (clk),
    .rstn   (rstn),
    .clr    (det_clr),
    .bit_en (det_en),
    .bit_in (shreg[DATA_W-1]),
    .hit    (det_hit)
  );

`ifdef SEQ_DET_IRQ_EN
  // Sticky threshold interrupt; clear has priority over a same-cycle set.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      irq <= 1'b0;
    end else if (irq_clr) begin
      irq <= 1'b0;
    end else if (rsp_valid && rsp_ready && (irq_thr != '0) && (rsp_cnt >= irq_thr)) begin
      irq <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_seq_det_sched.sv
// tb/tb_seq_det_sched.sv - self-checking bench for seq_det_sched (SEQ_DET_IRQ_EN optional)
module tb_seq_det_sched;

  localparam int N  = 4;
  localparam int DW = 8;

  logic          clk  = 1'b0;
  logic          rstn = 1'b0;
  logic [N-1:0]  req_valid;
  logic [N*DW-1:0] req_data;
  logic [N-1:0]  req_ready;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [1:0]    rsp_id;
  logic [3:0]    rsp_cnt;
  logic          busy;
`ifdef SEQ_DET_IRQ_EN
  logic [3:0]    irq_thr;
  logic          irq_clr;
  logic          irq;
`endif

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  seq_det_sched dut (
    .clk       (clk),
    .rstn      (rstn),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_cnt   (rsp_cnt),
    .busy      (busy)
`ifdef SEQ_DET_IRQ_EN
    ,
    .irq_thr   (irq_thr),
    .irq_clr   (irq_clr),
    .irq       (irq)
`endif
  );

  // Reference: hits equal the number of adjacent "0 then 1" pairs read MSB-first.
  function automatic int ref_hits(input logic [DW-1:0] w);
    int h;
    h = 0;
    for (int i = 0; i < DW - 1; i++) if (!w[i+1] && w[i]) h++;
    return h;
  endfunction

  function automatic int ref_pick(input logic [N-1:0] v, input int rr);
    int k;
    for (int i = 0; i < N; i++) begin
      k = (rr + i) % N;
      if (v[k]) return k;
    end
    return -1;
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rstn      = 1'b0;
    req_valid = '0;
    req_data  = '0;
    rsp_ready = 1'b0;
`ifdef SEQ_DET_IRQ_EN
    irq_thr = '0;
    irq_clr = 1'b0;
`endif
    repeat (2) @(posedge clk);
    #1;
    rstn = 1'b1;
  endtask

  task automatic wait_grant(output int n);
    n = 0;
    @(negedge clk);
    while (req_ready == '0) begin
      if (n >= 40) begin
        n = -1;
        return;
      end
      @(negedge clk);
      n++;
    end
  endtask

  task automatic wait_rsp(output int n);
    n = 0;
    @(negedge clk);
    while (rsp_valid !== 1'b1) begin
      if (n >= 40) begin
        n = -1;
        return;
      end
      @(negedge clk);
      n++;
    end
  endtask

  task automatic test_reset;
    rstn      = 1'b0;
    req_valid = 4'hF;
    req_data  = $urandom;
    rsp_ready = 1'b0;
    tick;
    @(negedge clk);
    checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL reset_req_ready got=%b exp=0000", req_ready); end
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid got=%b exp=0", rsp_valid); end
    checks++; if (rsp_id !== 2'd0) begin errors++; $display("FAIL reset_rsp_id got=%0d exp=0", rsp_id); end
    checks++; if (rsp_cnt !== 4'd0) begin errors++; $display("FAIL reset_rsp_cnt got=%0d exp=0", rsp_cnt); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
`ifdef SEQ_DET_IRQ_EN
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL reset_irq got=%b exp=0", irq); end
`endif
    rstn = 1'b1;
    #1;
    checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL reset_first_grant got=%b exp=0001", req_ready); end
    req_valid = '0;
  endtask

  task automatic test_counts;
    logic [DW-1:0] tbl [5];
    int            exp_tbl [5];
    int            id;
    bit            ok;
    tbl     = '{8'h55, 8'hFF, 8'h00, 8'h01, 8'h99};
    exp_tbl = '{4, 0, 0, 1, 2};
    do_reset;
    rsp_ready = 1'b1;
    for (int e = 0; e < 5; e++) begin
      id = e % N;
      req_data = $urandom;
      req_data[id*DW +: DW] = tbl[e];
      req_valid = 4'b1 << id;
      @(negedge clk);
      checks++; if (req_ready !== (4'b1 << id)) begin errors++; $display("FAIL cnt_grant[%0d] got=%b exp=%b", e, req_ready, 4'b1 << id); end
      tick;
      req_valid = '0;
      ok = 1'b1;
      for (int k = 1; k <= DW; k++) begin
        @(negedge clk);
        if (!(busy === 1'b1 && rsp_valid === 1'b0 && req_ready === 4'b0000)) ok = 1'b0;
        tick;
      end
      checks++; if (!ok) begin errors++; $display("FAIL cnt_shift_phase[%0d] got=0 exp=1", e); end
      @(negedge clk);
      checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL cnt_rsp_valid[%0d] got=%b exp=1", e, rsp_valid); end
      checks++; if (rsp_id !== id[1:0]) begin errors++; $display("FAIL cnt_rsp_id[%0d] got=%0d exp=%0d", e, rsp_id, id); end
      checks++; if (rsp_cnt !== exp_tbl[e][3:0]) begin errors++; $display("FAIL cnt_value[%0d] got=%0d exp=%0d", e, rsp_cnt, exp_tbl[e]); end
      tick;
      @(negedge clk);
      checks++; if (rsp_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL cnt_idle[%0d] got=%b%b exp=00", e, rsp_valid, busy); end
      tick;
    end
  endtask

  task automatic test_rr_order;
    int order [9];
    int n, last;
    order = '{0, 1, 2, 3, 0, 2, 3, 0, 2};
    last  = 0;
    do_reset;
    rsp_ready = 1'b1;
    req_data  = $urandom;
    req_valid = 4'hF;
    for (int j = 0; j < 9; j++) begin
      wait_grant(n);
      if (n < 0) begin
        checks++; errors++; $display("FAIL rr_timeout[%0d] got=none exp=%0d", j, order[j]);
      end else begin
        checks++; if (req_ready !== (4'b1 << order[j])) begin errors++; $display("FAIL rr_order[%0d] got=%b exp=%b", j, req_ready, 4'b1 << order[j]); end
        if (j > 0) begin
          checks++; if (cyc - last != DW + 2) begin errors++; $display("FAIL rr_spacing[%0d] got=%0d exp=%0d", j, cyc - last, DW + 2); end
        end
        last = cyc;
      end
      tick;
      if (j == 4) req_valid[1] = 1'b0;
    end
    req_valid = '0;
  endtask

  task automatic test_backpressure;
    logic [DW-1:0] w;
    int            n, exp_cnt;
    bit            ok;
    do_reset;
    rsp_ready = 1'b0;
    w = DW'($urandom);
    exp_cnt = ref_hits(w);
    req_data[2*DW +: DW] = w;
    req_valid = 4'b0100;
    wait_grant(n);
    checks++; if (req_ready !== 4'b0100) begin errors++; $display("FAIL bp_grant got=%b exp=0100", req_ready); end
    tick;
    req_valid = 4'b0001;
    wait_rsp(n);
    checks++; if (n != DW) begin errors++; $display("FAIL bp_latency got=%0d exp=%0d", n, DW); end
    ok = 1'b1;
    for (int k = 0; k < 5; k++) begin
      if (!(rsp_valid === 1'b1 && rsp_id === 2'd2 && rsp_cnt === exp_cnt[3:0] && busy === 1'b1 && req_ready === 4'b0000)) ok = 1'b0;
      tick;
      @(negedge clk);
    end
    checks++; if (!ok) begin errors++; $display("FAIL bp_hold got=%b/%0d/%0d exp=1/2/%0d", rsp_valid, rsp_id, rsp_cnt, exp_cnt); end
    rsp_ready = 1'b1;
    #1;
    checks++; if (rsp_valid !== 1'b1 || req_ready !== 4'b0000) begin errors++; $display("FAIL bp_handshake got=%b/%b exp=1/0000", rsp_valid, req_ready); end
    tick;
    rsp_ready = 1'b0;
    @(negedge clk);
    checks++; if (rsp_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL bp_release got=%b%b exp=00", rsp_valid, busy); end
    checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL bp_next_grant got=%b exp=0001", req_ready); end
    req_valid = '0;
    tick;
  endtask

  task automatic test_reset_mid;
    logic [DW-1:0] w1;
    int            n;
    do_reset;
    rsp_ready = 1'b1;
    req_data[3*DW +: DW] = 8'h55;
    req_valid = 4'b1000;
    wait_grant(n);
    tick;
    req_valid = '0;
    wait_rsp(n);
    tick;
    checks++; if (rsp_id !== 2'd3 || rsp_cnt !== 4'd4) begin errors++; $display("FAIL rm_prior got=%0d/%0d exp=3/4", rsp_id, rsp_cnt); end
    w1 = DW'($urandom);
    req_data[1*DW +: DW] = w1;
    req_valid = 4'b0010;
    wait_grant(n);
    checks++; if (req_ready !== 4'b0010) begin errors++; $display("FAIL rm_grant got=%b exp=0010", req_ready); end
    repeat (4) tick;
    #2;
    rstn = 1'b0;
    #1;
    checks++; if (req_ready !== 4'b0000 || rsp_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL rm_outputs got=%b/%b/%b exp=0000/0/0", req_ready, rsp_valid, busy); end
    checks++; if (rsp_id !== 2'd0 || rsp_cnt !== 4'd0) begin errors++; $display("FAIL rm_rsp_regs got=%0d/%0d exp=0/0", rsp_id, rsp_cnt); end
    tick;
    rstn = 1'b1;
    wait_grant(n);
    checks++; if (n != 0 || req_ready !== 4'b0010) begin errors++; $display("FAIL rm_regrant got=%b@%0d exp=0010@0", req_ready, n); end
    tick;
    req_valid = '0;
    wait_rsp(n);
    checks++; if (n < 0 || rsp_id !== 2'd1 || rsp_cnt !== 4'(ref_hits(w1))) begin errors++; $display("FAIL rm_result got=%0d/%0d exp=1/%0d", rsp_id, rsp_cnt, ref_hits(w1)); end
    tick;
  endtask

  task automatic test_random;
    logic [N-1:0]  pend;
    logic [DW-1:0] wd [N];
    logic [N-1:0]  exp_rdy;
    int            rr, g, m_gc, m_id, m_cnt;
    bit            m_busy, exp_rv;
    do_reset;
    pend = '0; rr = 0; m_busy = 1'b0; m_gc = 0; m_id = 0; m_cnt = 0;
    for (int i = 0; i < N; i++) wd[i] = '0;
    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!pend[i] && $urandom_range(0, 2) == 0) begin
          pend[i] = 1'b1;
          case ($urandom_range(0, 5))
            0: wd[i] = 8'h00;
            1: wd[i] = 8'hFF;
            2: wd[i] = 8'h55;
            3: wd[i] = 8'hAA;
            default: wd[i] = DW'($urandom);
          endcase
        end
        req_data[i*DW +: DW] = pend[i] ? wd[i] : DW'($urandom);
      end
      req_valid = pend;
      rsp_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      exp_rv  = m_busy && (cyc - m_gc >= DW + 1);
      g       = m_busy ? -1 : ref_pick(pend, rr);
      exp_rdy = (g >= 0) ? (4'b1 << g) : 4'b0000;
      checks++; if (req_ready !== exp_rdy) begin errors++; $display("FAIL rnd_ready@%0d got=%b exp=%b", c, req_ready, exp_rdy); end
      checks++; if (rsp_valid !== exp_rv) begin errors++; $display("FAIL rnd_rsp_valid@%0d got=%b exp=%b", c, rsp_valid, exp_rv); end
      checks++; if (busy !== m_busy) begin errors++; $display("FAIL rnd_busy@%0d got=%b exp=%b", c, busy, m_busy); end
      if (exp_rv) begin
        checks++; if (rsp_id !== m_id[1:0] || rsp_cnt !== m_cnt[3:0]) begin errors++; $display("FAIL rnd_result@%0d got=%0d/%0d exp=%0d/%0d", c, rsp_id, rsp_cnt, m_id, m_cnt); end
      end
      if (g >= 0) begin
        m_busy = 1'b1; m_gc = cyc; m_id = g; m_cnt = ref_hits(wd[g]);
        rr = (g + 1) % N;
        pend[g] = 1'b0;
      end else if (exp_rv && rsp_ready) begin
        m_busy = 1'b0;
      end
      tick;
    end
    req_valid = '0;
    rsp_ready = 1'b0;
  endtask

`ifdef SEQ_DET_IRQ_EN
  task automatic drive_word(input int id, input logic [DW-1:0] w, input bit clr_hs, output bit ok);
    int n;
    ok = 1'b1;
    req_data[id*DW +: DW] = w;
    req_valid = 4'b1 << id;
    wait_grant(n);
    if (n < 0) ok = 1'b0;
    tick;
    req_valid = '0;
    wait_rsp(n);
    if (n < 0) ok = 1'b0;
    irq_clr = clr_hs;
    tick;
    irq_clr = 1'b0;
  endtask

  task automatic test_irq;
    bit ok;
    do_reset;
    rsp_ready = 1'b1;
    irq_thr   = 4'd3;
    drive_word(0, 8'h55, 1'b0, ok);
    @(negedge clk);
    checks++; if (!ok || irq !== 1'b1) begin errors++; $display("FAIL irq_set_cnt4 got=%b exp=1", irq); end
    irq_clr = 1'b1;
    tick;
    irq_clr = 1'b0;
    @(negedge clk);
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL irq_clear got=%b exp=0", irq); end
    drive_word(1, 8'h99, 1'b0, ok);
    @(negedge clk);
    checks++; if (!ok || irq !== 1'b0) begin errors++; $display("FAIL irq_cnt2_noset got=%b exp=0", irq); end
    drive_word(2, 8'h55, 1'b1, ok);
    @(negedge clk);
    checks++; if (!ok || irq !== 1'b0) begin errors++; $display("FAIL irq_clr_wins got=%b exp=0", irq); end
    irq_thr = 4'd0;
    drive_word(3, 8'h55, 1'b0, ok);
    @(negedge clk);
    checks++; if (!ok || irq !== 1'b0) begin errors++; $display("FAIL irq_thr0 got=%b exp=0", irq); end
    irq_thr = 4'd4;
    drive_word(0, 8'h55, 1'b0, ok);
    @(negedge clk);
    checks++; if (!ok || irq !== 1'b1) begin errors++; $display("FAIL irq_thr_equal got=%b exp=1", irq); end
    tick;
  endtask
`endif

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    req_valid = '0;
    req_data  = '0;
    rsp_ready = 1'b0;
`ifdef SEQ_DET_IRQ_EN
    irq_thr = '0;
    irq_clr = 1'b0;
`endif
    test_reset;
    test_counts;
    test_rr_order;
    test_backpressure;
    test_reset_mid;
    test_random;
`ifdef SEQ_DET_IRQ_EN
    test_irq;
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
